// File: rtl/ble_cmd_parser.sv
// Line-oriented command parser: collects up to six ASCII digits, commits them to a
// six-digit BCD display word on CR/LF, with backspace, clear, error drain and idle timeout.
module ble_cmd_parser #(
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [7:0]  rdata,
  input  logic        rx_sig,
  output logic [23:0] disp_bcd,
  output logic        disp_valid,
  output logic        cmd_err,
  output logic [2:0]  digit_cnt,
  output logic        busy
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] IDLE_MAX = CW'(TIMEOUT_CYC - 1);
  localparam logic [23:0] BLANK = 24'hFFFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t          r_state;
  logic [23:0]     r_wbuf;
  logic [2:0]      r_count;
  logic [CW-1:0]   r_idle;
  logic [23:0]     r_disp;
  logic            r_valid;
  logic            r_err;
  logic            r_busy;

  state_t          w_state_nx;
  logic [23:0]     w_wbuf_nx;
  logic [2:0]      w_count_nx;
  logic [CW-1:0]   w_idle_nx;
  logic [23:0]     w_disp_nx;
  logic            w_valid_nx;
  logic            w_err_nx;

  logic            w_is_digit;
  logic            w_is_term;
  logic            w_is_bs;
  logic            w_is_clr;

  assign w_is_digit = (rdata >= 8'h30) && (rdata <= 8'h39);
  assign w_is_term  = (rdata == 8'h0D) || (rdata == 8'h0A);
  assign w_is_bs    = (rdata == 8'h08);
  assign w_is_clr   = (rdata == 8'h43) || (rdata == 8'h63);

  // Register stage: every output comes straight from a flop.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_wbuf  <= BLANK;
      r_count <= 3'd0;
      r_idle  <= '0;
      r_disp  <= BLANK;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_wbuf  <= w_wbuf_nx;
      r_count <= w_count_nx;
      r_idle  <= w_idle_nx;
      r_disp  <= w_disp_nx;
      r_valid <= w_valid_nx;
      r_err   <= w_err_nx;
      r_busy  <= (w_state_nx != IDLE);
    end
  end

  // Next-state decode; an accepted byte always takes priority over the idle timeout.
  always_comb begin
    w_state_nx = r_state;
    w_wbuf_nx  = r_wbuf;
    w_count_nx = r_count;
    w_idle_nx  = r_idle;
    w_disp_nx  = r_disp;
    w_valid_nx = 1'b0;
    w_err_nx   = 1'b0;
    if (rx_sig) begin
      w_idle_nx = '0;
      if (w_is_clr) begin
        w_disp_nx  = BLANK;
        w_valid_nx = 1'b1;
        w_wbuf_nx  = BLANK;
        w_count_nx = 3'd0;
        w_state_nx = IDLE;
      end else begin
        case (r_state)
          IDLE, COLLECT: begin
            if (w_is_digit) begin
              if (r_count < 3'd6) begin
                w_wbuf_nx  = {r_wbuf[19:0], rdata[3:0]};
                w_count_nx = r_count + 3'd1;
                w_state_nx = COLLECT;
              end else begin
                w_err_nx   = 1'b1;
                w_wbuf_nx  = BLANK;
                w_count_nx = 3'd0;
                w_state_nx = DRAIN;
              end
            end else if (w_is_term) begin
              if (r_state == COLLECT) begin
                w_disp_nx  = r_wbuf;
                w_valid_nx = 1'b1;
                w_wbuf_nx  = BLANK;
                w_count_nx = 3'd0;
                w_state_nx = IDLE;
              end else begin
                w_state_nx = IDLE;
              end
            end else if (w_is_bs) begin
              if (r_state == COLLECT) begin
                w_wbuf_nx  = {4'hF, r_wbuf[23:4]};
                w_count_nx = r_count - 3'd1;
                if (r_count == 3'd1) begin
                  w_state_nx = IDLE;
                end else begin
                  w_state_nx = COLLECT;
                end
              end else begin
                w_state_nx = IDLE;
              end
            end else begin
              w_err_nx   = 1'b1;
              w_wbuf_nx  = BLANK;
              w_count_nx = 3'd0;
              w_state_nx = DRAIN;
            end
          end
          DRAIN: begin
            if (w_is_term) begin
              w_state_nx = IDLE;
            end else begin
              w_state_nx = DRAIN;
            end
          end
          default: begin
            w_wbuf_nx  = BLANK;
            w_count_nx = 3'd0;
            w_state_nx = IDLE;
          end
        endcase
      end
    end else if (r_state == IDLE) begin
      w_idle_nx = '0;
    end else if (r_idle == IDLE_MAX) begin
      w_idle_nx  = '0;
      w_wbuf_nx  = BLANK;
      w_count_nx = 3'd0;
      w_state_nx = IDLE;
    end else begin
      w_idle_nx = r_idle + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign disp_bcd   = r_disp;
  assign disp_valid = r_valid;
  assign cmd_err    = r_err;
  assign digit_cnt  = r_count;
  assign busy       = r_busy;

endmodule

// File: doc/ble_cmd_parser.md
BLE_CMD_PARSER -- requirements
Module: ble_cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 50_000_000, meaning idle sys_clk cycles after which a partial line is discarded (legal range 2..2^26).
REQ-002 SHALL have port sys_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rdata  input  8  received byte; sampled only while rx_sig=1.
REQ-005 SHALL have port rx_sig  input  1  byte strobe; every high cycle is one byte, including back-to-back highs.
REQ-006 SHALL have port disp_bcd  output  24  six digits, [23:20]=leftmost, 4'hF=blank digit; feeds the segment display stage.
REQ-007 SHALL have port disp_valid  output  1  one-cycle pulse when disp_bcd is updated.
REQ-008 SHALL have port cmd_err  output  1  one-cycle pulse on a protocol error.
REQ-009 SHALL have port digit_cnt  output  3  digits held in the work buffer, 0..6.
REQ-010 SHALL have port busy  output  1  high when state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, COLLECT, DRAIN; all outputs registered, updated on the sys_clk edge that samples rx_sig=1 (latency 1 cycle).
REQ-012 SHALL hold a 24-bit work buffer wbuf (reset and clear value 24'hFFFFFF) and a 3-bit count.
REQ-013 SHALL, on digit byte 0x30..0x39 in IDLE or COLLECT with count<6, set wbuf <= {wbuf[19:0], rdata[3:0]}, count+1, state COLLECT.
REQ-014 SHALL, on a digit byte with count=6, pulse cmd_err, clear wbuf and count, and enter DRAIN.
REQ-015 SHALL, on terminator 0x0D or 0x0A in COLLECT, load disp_bcd <= wbuf, pulse disp_valid, clear wbuf and count, and enter IDLE.
REQ-016 SHALL ignore a terminator in IDLE (no pulse), so CR-LF commits exactly once.
REQ-017 SHALL, on a terminator in DRAIN, enter IDLE without changing disp_bcd or pulsing disp_valid.
REQ-018 SHALL, on backspace 0x08 in COLLECT, set wbuf <= {4'hF, wbuf[23:4]}, count-1; at count reaching 0, enter IDLE; in IDLE or DRAIN ignore backspace.
REQ-019 SHALL, on 0x43 or 0x63 ('C'/'c') in any state, set disp_bcd <= 24'hFFFFFF, pulse disp_valid, clear wbuf and count, and enter IDLE.
REQ-020 SHALL, on any other byte in IDLE or COLLECT, pulse cmd_err, clear wbuf and count, and enter DRAIN; in DRAIN such bytes are silently discarded.
REQ-021 SHALL run an idle counter in COLLECT and DRAIN, cleared by every rx_sig=1 cycle; when it reaches TIMEOUT_CYC-1, SHALL clear wbuf and count, and enter IDLE on the next edge without pulses.
REQ-022 SHALL hold the idle counter at 0 in IDLE and SHALL size it to $clog2(TIMEOUT_CYC).
REQ-023 SHALL give a byte accepted on the same cycle as timeout expiry priority over the timeout.
REQ-024 SHALL drive digit_cnt equal to count and busy = (state != IDLE) from registers.
REQ-025 SHALL never assert disp_valid and cmd_err in the same cycle.

Reset
REQ-026 SHALL, while rst_n=0, force state IDLE, wbuf=24'hFFFFFF, count=0, idle counter=0, disp_bcd=24'hFFFFFF, disp_valid=0, cmd_err=0, digit_cnt=0, busy=0.
REQ-027 SHALL, on reset mid-line, discard the partial line; the first byte after release is parsed from IDLE.

Verification
REQ-028 SHALL cover: bytes "123" then 0x0D,0x0A -> disp_bcd=24'hFFF123, one disp_valid pulse, busy=0.
REQ-029 SHALL cover: "1234567" then 0x0D -> cmd_err pulse on the '7'; disp_bcd unchanged; IDLE after CR.
REQ-030 SHALL cover: "45", 0x08, "9", 0x0D -> disp_bcd=24'hFFFF49, digit_cnt sequence 1,2,1,2,0.
REQ-031 SHALL cover: "12" then 0x41 ('A'), "3", 0x0D -> cmd_err once; disp_bcd unchanged; IDLE.
REQ-032 SHALL cover, with TIMEOUT_CYC=16: "8" then 16 idle cycles, then "5", 0x0D -> disp_bcd=24'hFFFFF5.
REQ-033 SHALL cover: commit "99", then 'c' -> disp_bcd=24'hFFFFFF with disp_valid pulse; back-to-back rx_sig strobes and rst_n low mid-line also exercised.
